// File: rtl/tt_um_ram_pkg.sv
// Shared constants and types for the tt_um_ram byte RAM macro.
package tt_um_ram_pkg;

   localparam int unsigned ADDR_W_DEFAULT = 6;
   localparam int unsigned DATA_W         = 8;

   // Bit positions within ui_in
   localparam int unsigned ADDR_LSB = 0;
   localparam int unsigned WE_BIT   = 6;
   localparam int unsigned RE_BIT   = 7;

   typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/tt_um_ram_array.sv
// Single-port synchronous byte storage with a write-first registered read port.
// Optional macro RAM_RESET_CLEAR_EN: reset also zeroes every stored word.
module ram_array
   import tt_um_ram_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] addr,
   input  data_t             din,
   output data_t             dout
);

   localparam int unsigned Depth = 2 ** ADDR_W;

   data_t mem_q [Depth];
   data_t dout_q;
   data_t dout_d;

   // Read data selection: same-cycle write forwards the new byte
   always_comb begin
      dout_d = dout_q;
      if (en && re) begin
         dout_d = we ? din : mem_q[addr];
      end
   end

   // Read data register; reset wins over enable
   always_ff @(posedge clk) begin
      if (rst) begin
         dout_q <= '0;
      end else begin
         dout_q <= dout_d;
      end
   end

`ifdef RAM_RESET_CLEAR_EN
   // Storage with reset clearing every word
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < Depth; i++) begin
            mem_q[i] <= '0;
         end
      end else if (en && we) begin
         mem_q[addr] <= din;
      end
   end
`else
   // Reset-free storage; reset only blocks the write
   always_ff @(posedge clk) begin
      if (!rst && en && we) begin
         mem_q[addr] <= din;
      end
   end
`endif

   assign dout = dout_q;

endmodule

// File: rtl/tt_um_ram.sv
// TinyTapeout wrapper around ram_array: pin mapping and constant ties only.
// Optional macro RAM_RESET_CLEAR_EN (handled inside ram_array).
// Note: rst_n is active-high here (reset when rst_n=1), sampled on clk.
module tt_um_ram
   import tt_um_ram_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic [DATA_W-1:0] ui_in,
   input  logic [DATA_W-1:0] uio_in,
   output logic [DATA_W-1:0] uo_out,
   output logic [DATA_W-1:0] uio_out,
   output logic [DATA_W-1:0] uio_oe
);

   data_t dout;

   ram_array #(
      .ADDR_W (ADDR_W)
   ) u_ram_array (
      .clk  (clk),
      .rst  (rst_n),
      .en   (ena),
      .we   (ui_in[WE_BIT]),
      .re   (ui_in[RE_BIT]),
      .addr (ui_in[ADDR_LSB +: ADDR_W]),
      .din  (uio_in),
      .dout (dout)
   );

   assign uo_out  = dout;
   // Bidirectional pins are used purely as inputs
   assign uio_out = '0;
   assign uio_oe  = '0;

endmodule

// File: tb/tb_tt_um_ram.sv
// Directed self-checking bench for tt_um_ram.
module tb_tt_um_ram;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int n_total;
   int n_pass;

   tt_um_ram dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uo_out  (uo_out),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of stimulus, then sample 1 time unit after the edge
   task automatic step(input logic rst, input logic en, input logic we, input logic re,
                       input logic [5:0] addr, input logic [7:0] din);
      rst_n  = rst;
      ena    = en;
      ui_in  = {re, we, addr};
      uio_in = din;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_total++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, got, exp);
   endtask

   logic [7:0] exp_after_reset;

   initial begin
      n_total = 0;
      n_pass  = 0;
`ifdef RAM_RESET_CLEAR_EN
      exp_after_reset = 8'h00;
`else
      exp_after_reset = 8'h5A;
`endif
      rst_n = 1'b1; ena = 1'b0; ui_in = '0; uio_in = '0;

      // Reset, held for two edges
      step(1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 8'h00);
      step(1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 8'h00);
      check("reset_dout", uo_out, 8'h00);
      check("reset_uio_oe", uio_oe, 8'h00);
      check("reset_uio_out", uio_out, 8'h00);

      // Write addr0=00, addr5=A5, addr63=3C back to back
      step(1'b0, 1'b1, 1'b1, 1'b0, 6'd0, 8'h00);
      step(1'b0, 1'b1, 1'b1, 1'b0, 6'd5, 8'hA5);
      step(1'b0, 1'b1, 1'b1, 1'b0, 6'd63, 8'h3C);
      check("write_no_read_hold", uo_out, 8'h00);

      // Back-to-back reads, one-cycle latency each
      step(1'b0, 1'b1, 1'b0, 1'b1, 6'd5, 8'h00);
      check("read_addr5", uo_out, 8'hA5);
      step(1'b0, 1'b1, 1'b0, 1'b1, 6'd63, 8'h00);
      check("read_addr63", uo_out, 8'h3C);
      step(1'b0, 1'b1, 1'b0, 1'b1, 6'd0, 8'h00);
      check("read_addr0", uo_out, 8'h00);

      // Same-cycle write and read: write-first
      step(1'b0, 1'b1, 1'b1, 1'b1, 6'd10, 8'h77);
      check("write_first", uo_out, 8'h77);

      // ena=0 blocks write and freezes dout
      step(1'b0, 1'b0, 1'b1, 1'b1, 6'd5, 8'hFF);
      check("ena0_dout_hold", uo_out, 8'h77);
      step(1'b0, 1'b1, 1'b0, 1'b1, 6'd5, 8'h00);
      check("ena0_write_blocked", uo_out, 8'hA5);
      step(1'b0, 1'b1, 1'b0, 1'b1, 6'd10, 8'h00);
      check("readback_addr10", uo_out, 8'h77);

      // re=0 holds dout across a write elsewhere
      step(1'b0, 1'b1, 1'b0, 1'b1, 6'd63, 8'h00);
      check("read_addr63_again", uo_out, 8'h3C);
      step(1'b0, 1'b1, 1'b1, 1'b0, 6'd20, 8'h11);
      check("re0_hold", uo_out, 8'h3C);
      step(1'b0, 1'b1, 1'b0, 1'b1, 6'd20, 8'h00);
      check("read_addr20", uo_out, 8'h11);

      // Write 5A to addr2, then reset with ena=0 and a competing write
      step(1'b0, 1'b1, 1'b1, 1'b0, 6'd2, 8'h5A);
      step(1'b1, 1'b0, 1'b1, 1'b1, 6'd2, 8'hEE);
      check("reset_overrides_ena", uo_out, 8'h00);
      // First edge after release is a normal cycle
      step(1'b0, 1'b1, 1'b0, 1'b1, 6'd2, 8'h00);
      check("read_addr2_after_reset", uo_out, exp_after_reset);

      check("end_uio_oe", uio_oe, 8'h00);
      check("end_uio_out", uio_out, 8'h00);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
